systolic_sched: RTL and testbench
=================================

# systolic_sched

Round-robin scheduler that shares one combinational ROW×COLUMN systolic NOR array among NREQ requesters. Accepts one operand pair (row vector, column vector) at a time, registers it onto the array inputs, waits SETTLE cycles for the NOR grid to resolve, samples the single-bit array output and returns it to the winning requester with a valid/ready handshake. Sits between the requester fabric and the array instance; the array itself is instantiated outside this block.

## Interface
- ROW, 4, array row-input width
- COLUMN, 12, array column-input width
- NREQ, 4, number of requesters (≥2)
- SETTLE, 3, cycles operands are held before sampling `arr_out` (≥1; 0 is an elaboration error)
- IDW, $clog2(NREQ), derived requester-id width (localparam)

- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  NREQ  per-requester request
- req_ready  out  NREQ  one-hot accept strobe
- req_row  in  NREQ*ROW  requester k at [k*ROW +: ROW]
- req_col  in  NREQ*COLUMN  requester k at [k*COLUMN +: COLUMN]
- arr_row  out  ROW  registered drive to array row inputs
- arr_col  out  COLUMN  registered drive to array column inputs
- arr_out  in  1  array result
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  IDW  index of requester owning result
- rsp_data  out  1  sampled array result
- busy  out  1  high in any state but IDLE
- op_count  out  16  completed operations (only with SYSTOLIC_SCHED_CNT_EN)

## Operation
- FSM states: IDLE, SETTLE, RESP.
- IDLE: if any req_valid, arbiter picks winner g; req_ready[g]=1 combinationally this cycle (all others 0); on the clock edge latch req_row/req_col slice g into arr_row/arr_col, g into rsp_id, load settle counter with SETTLE-1, go SETTLE. No req_valid: stay, req_ready=0.
- SETTLE: counter decrements each cycle; when 0, register arr_out into rsp_data, set rsp_valid, go RESP.
- RESP: hold rsp_valid, rsp_id, rsp_data stable until rsp_valid&rsp_ready; then clear rsp_valid, go IDLE. rsp_ready ignored in other states.
- Arbitration: round-robin; pointer = (last grant + 1) mod NREQ; search starts at pointer, wraps. Pointer updates only on acceptance. Reset pointer 0 (requester 0 first).
- Requesters hold req_valid and operands stable until req_ready; dropping valid earlier is legal and simply loses arbitration.
- arr_row/arr_col keep last operands after completion (not cleared).
- req_ready never asserted outside IDLE; at most one request in flight.

## Timing
- Reset (rst_n=0 at edge): state IDLE, req_ready=0, arr_row=0, arr_col=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0, pointer=0, op_count=0. Reset mid-operation abandons in-flight request; no response issued.
- Accept in cycle 0 → operands on arr_* from cycle 1 → arr_out sampled end of cycle SETTLE → rsp_valid high from cycle SETTLE+1.
- With rsp_ready held high: response handshake in cycle SETTLE+1, IDLE in SETTLE+2, next accept earliest SETTLE+2; issue period SETTLE+2 cycles.
- Backpressure: rsp_ready low stalls in RESP indefinitely; outputs stable.
- All outputs registered except req_ready (combinational from state, req_valid, pointer).

## Configuration
- SYSTOLIC_SCHED_CNT_EN defined: op_count port present; 16-bit counter increments on each response handshake, wraps 0xFFFF→0x0000, reset 0.
- Undefined: op_count port and counter absent; all other behaviour identical.

## Structure
- Package systolic_sched_pkg: state enum (IDLE, SETTLE, RESP), default ROW/COLUMN/NREQ/SETTLE constants, op_count width constant (16).
- Sub-module rr_arbiter (parameter NREQ): inputs req vector, pointer, enable; outputs one-hot grant and binary grant index. Pointer register lives in systolic_sched.

## Test plan
- Single request: req_valid=4'b0100, row=4'hF, col=12'h000, arr_out tied 1 → req_ready=4'b0100 in cycle 0, arr_row=4'hF from cycle 1, rsp_valid cycle 4 (SETTLE=3), rsp_id=2, rsp_data=1.
- All requesters valid continuously, rsp_ready=1 → grants in order 0,1,2,3,0, each 5 cycles apart.
- rsp_ready low 10 cycles in RESP → rsp_valid/rsp_id/rsp_data stable, req_ready=0 throughout, then one handshake and return to IDLE.
- Bench-driven array model (NOR grid golden model on arr_row/arr_col), 200 random operand pairs → every rsp_data matches model, rsp_id matches issuing requester.
- rst_n=0 during SETTLE → next cycle all outputs at reset values, no rsp_valid, next grant goes to requester 0.
- With SYSTOLIC_SCHED_CNT_EN, 3 completed handshakes → op_count=3; preset wrap test 0xFFFF +1 → 0x0000.

Source files
------------

// File: rtl/systolic_sched_pkg.sv
// systolic_sched_pkg: shared types and default constants for the systolic NOR
// array scheduler.
//   state_e      scheduler FSM states (idle, operands settling, response held)
//   Def*         default array geometry, requester count and settle time
//   OpCountW     width of the optional completed-operation counter
package systolic_sched_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StResp
  } state_e;

  localparam int unsigned DefRow    = 4;
  localparam int unsigned DefColumn = 12;
  localparam int unsigned DefNreq   = 4;
  localparam int unsigned DefSettle = 3;
  localparam int unsigned OpCountW  = 16;

endpackage

// File: rtl/systolic_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter. The search starts at `pointer`
// and wraps around; the pointer register itself is owned by the caller.
//   req        in   NREQ  request vector
//   pointer    in   IDW   highest-priority requester index
//   enable     in   1     when low, no grant is issued
//   grant      out  NREQ  one-hot grant (all zero when nothing granted)
//   grant_idx  out  IDW   binary index of the granted requester (0 if none)
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  localparam int unsigned IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  pointer,
  input  logic            enable,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx
);

  logic [NREQ-1:0] req_en;
  logic            found;

  assign req_en = enable ? req : '0;

  // Two passes: first the indices at or above the pointer, then the wrapped
  // lower indices. The first hit wins, giving rotating priority.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_en[k] && (IDW'(k) >= pointer)) begin
        found     = 1'b1;
        grant[k]  = 1'b1;
        grant_idx = IDW'(k);
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_en[k]) begin
        found     = 1'b1;
        grant[k]  = 1'b1;
        grant_idx = IDW'(k);
      end
    end
  end

endmodule

// File: rtl/systolic_sched.sv
// systolic_sched: round-robin scheduler sharing one combinational ROW x COLUMN
// NOR array among NREQ requesters. One operand pair is in flight at a time:
// accept, hold operands on the array for SETTLE cycles, sample arr_out, then
// present the result until the consumer takes it.
// Optional feature: define SYSTOLIC_SCHED_CNT_EN to add the op_count port, a
// 16-bit wrapping count of completed response handshakes.
//   clk        in   1           rising-edge clock
//   rst_n      in   1           synchronous active-low reset
//   req_valid  in   NREQ        per-requester request
//   req_ready  out  NREQ        one-hot accept strobe (combinational)
//   req_row    in   NREQ*ROW    requester k row operand at [k*ROW +: ROW]
//   req_col    in   NREQ*COLUMN requester k column operand at [k*COLUMN +: COLUMN]
//   arr_row    out  ROW         registered array row drive
//   arr_col    out  COLUMN      registered array column drive
//   arr_out    in   1           array result
//   rsp_valid  out  1           result available
//   rsp_ready  in   1           consumer accepts result
//   rsp_id     out  IDW         requester owning the result
//   rsp_data   out  1           sampled array result
//   op_count   out  16          completed operations (SYSTOLIC_SCHED_CNT_EN only)
//   busy       out  1           high whenever not idle
module systolic_sched
  import systolic_sched_pkg::*;
#(
  parameter int unsigned ROW    = DefRow,
  parameter int unsigned COLUMN = DefColumn,
  parameter int unsigned NREQ   = DefNreq,
  parameter int unsigned SETTLE = DefSettle,
  localparam int unsigned IDW   = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*ROW-1:0]    req_row,
  input  logic [NREQ*COLUMN-1:0] req_col,
  output logic [ROW-1:0]         arr_row,
  output logic [COLUMN-1:0]      arr_col,
  input  logic                   arr_out,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic                   rsp_data,
`ifdef SYSTOLIC_SCHED_CNT_EN
  output logic [OpCountW-1:0]    op_count,
`endif
  output logic                   busy
);

  // Counter must hold SETTLE-1; keep at least one bit when SETTLE is 1.
  localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  if (SETTLE < 1) begin : g_settle_check
    $error("systolic_sched: SETTLE must be at least 1");
  end
  if (NREQ < 2) begin : g_nreq_check
    $error("systolic_sched: NREQ must be at least 2");
  end

  state_e              state_q;
  logic [IDW-1:0]      ptr_q;
  logic [CW-1:0]       cnt_q;
  logic [ROW-1:0]      arr_row_q;
  logic [COLUMN-1:0]   arr_col_q;
  logic                rsp_valid_q;
  logic [IDW-1:0]      rsp_id_q;
  logic                rsp_data_q;

  logic [NREQ-1:0]     grant;
  logic [IDW-1:0]      grant_idx;
  logic [IDW-1:0]      next_ptr;
  logic [ROW-1:0]      sel_row;
  logic [COLUMN-1:0]   sel_col;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .req       (req_valid),
    .pointer   (ptr_q),
    .enable    (state_q == StIdle),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Next search starts just past the winner.
  assign next_ptr = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);

  // Operand mux driven by the one-hot grant.
  always_comb begin
    sel_row = '0;
    sel_col = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant[k]) begin
        sel_row = req_row[k*ROW +: ROW];
        sel_col = req_col[k*COLUMN +: COLUMN];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      cnt_q       <= '0;
      arr_row_q   <= '0;
      arr_col_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|grant) begin
            arr_row_q <= sel_row;
            arr_col_q <= sel_col;
            rsp_id_q  <= grant_idx;
            ptr_q     <= next_ptr;
            cnt_q     <= CW'(SETTLE - 1);
            state_q   <= StSettle;
          end
        end
        StSettle: begin
          if (cnt_q == '0) begin
            rsp_data_q  <= arr_out;
            rsp_valid_q <= 1'b1;
            state_q     <= StResp;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef SYSTOLIC_SCHED_CNT_EN
  logic [OpCountW-1:0] op_count_q;
  logic                rsp_hs;

  assign rsp_hs = (state_q == StResp) && rsp_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_count_q <= '0;
    end else if (rsp_hs) begin
      op_count_q <= op_count_q + OpCountW'(1);
    end
  end

  assign op_count = op_count_q;
`endif

  assign req_ready = grant;
  assign arr_row   = arr_row_q;
  assign arr_col   = arr_col_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_systolic_sched.sv
// tb_systolic_sched: randomized self-checking bench for systolic_sched. A driver
// loop plays the requesters and predicts each accept from the round-robin rule;
// accepted work is pushed to a scoreboard queue that a separate monitor drains
// whenever a response handshake occurs. The array is a NOR-grid model on the
// DUT's arr_row/arr_col pins.
module tb_systolic_sched;
  import systolic_sched_pkg::*;

  localparam int ROW    = 4;
  localparam int COLUMN = 12;
  localparam int NREQ   = 4;
  localparam int SETTLE = 3;
  localparam int IDW    = 2;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [NREQ-1:0]        req_valid = '0;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*ROW-1:0]    req_row = '0;
  logic [NREQ*COLUMN-1:0] req_col = '0;
  logic [ROW-1:0]         arr_row;
  logic [COLUMN-1:0]      arr_col;
  logic                   arr_out;
  logic                   rsp_valid;
  logic                   rsp_ready = 1'b0;
  logic [IDW-1:0]         rsp_id;
  logic                   rsp_data;
  logic                   busy;
`ifdef SYSTOLIC_SCHED_CNT_EN
  logic [15:0]            op_count;
`endif

  systolic_sched #(
    .ROW    (ROW),
    .COLUMN (COLUMN),
    .NREQ   (NREQ),
    .SETTLE (SETTLE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_row   (req_row),
    .req_col   (req_col),
    .arr_row   (arr_row),
    .arr_col   (arr_col),
    .arr_out   (arr_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
`ifdef SYSTOLIC_SCHED_CNT_EN
    .op_count  (op_count),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Array golden model: each cell is NOR of its row and column line; the
  // single output is the parity over all cells.
  function automatic bit nor_grid(logic [ROW-1:0] r, logic [COLUMN-1:0] c);
    bit acc = 1'b0;
    for (int i = 0; i < ROW; i++)
      for (int j = 0; j < COLUMN; j++)
        acc ^= ~(r[i] | c[j]);
    return acc;
  endfunction

  bit tie1 = 1'b0;
  assign arr_out = tie1 ? 1'b1 : nor_grid(arr_row, arr_col);

  typedef struct {
    int     id;
    bit     data;
    longint acc_cyc;
  } exp_t;

  exp_t              exp_q[$];
  int                grants[$];
  longint            grant_cyc[$];
  bit                pend[NREQ];
  logic [ROW-1:0]    prow[NREQ];
  logic [COLUMN-1:0] pcol[NREQ];
  int                mptr = 0;
  bit                in_flight = 1'b0;
  int                gen_mode = 0;   // 0 none, 1 random, 2 all requesters always
  int                rdy_mode = 1;   // 0 low, 1 high, 2 random
  int                accepts = 0;
  int                hs_count = 0;
  longint            cyc = 0;
  int                checks = 0;
  int                failures = 0;

  always @(posedge clk) cyc++;

  task automatic check(string name, longint act, longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < NREQ; k++) begin
      req_valid[k]                = pend[k];
      req_row[k*ROW +: ROW]       = prow[k];
      req_col[k*COLUMN +: COLUMN] = pcol[k];
    end
  endtask

  function automatic bit any_pend();
    bit a = 1'b0;
    for (int k = 0; k < NREQ; k++) a |= pend[k];
    return a;
  endfunction

  // One clock cycle: predict and check the accept at the negedge, then update
  // requesters after the edge.
  task automatic tick();
    int w;
    @(negedge clk);
    w = -1;
    if (!in_flight) begin
      for (int i = 0; i < NREQ; i++) begin
        int k = (mptr + i) % NREQ;
        if (w < 0 && req_valid[k]) w = k;
      end
    end
    check("busy", longint'(busy), longint'(in_flight));
    check("req_ready", longint'(req_ready), (w < 0) ? 0 : (longint'(1) << w));
`ifdef SYSTOLIC_SCHED_CNT_EN
    check("op_count", longint'(op_count), longint'(hs_count % 65536));
`endif
    if (w >= 0) begin
      exp_q.push_back('{w, tie1 ? 1'b1 : nor_grid(prow[w], pcol[w]), cyc});
      grants.push_back(w);
      grant_cyc.push_back(cyc);
      mptr      = (w + 1) % NREQ;
      in_flight = 1'b1;
      accepts++;
    end
    @(posedge clk);
    #1;
    if (w >= 0) pend[w] = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!pend[k] && ((gen_mode == 2) || (gen_mode == 1 && $urandom_range(0, 3) == 0))) begin
        pend[k] = 1'b1;
        prow[k] = ROW'($urandom);
        pcol[k] = COLUMN'($urandom);
      end
    end
    case (rdy_mode)
      0:       rsp_ready = 1'b0;
      1:       rsp_ready = 1'b1;
      default: rsp_ready = ($urandom_range(0, 9) < 7);
    endcase
    drive();
  endtask

  // Apply reset for one edge (called just after a rising edge) and check the
  // reset values of every output.
  task automatic do_reset();
    rst_n = 1'b0;
    for (int k = 0; k < NREQ; k++) pend[k] = 1'b0;
    drive();
    @(posedge clk);
    #1;
    exp_q.delete();
    in_flight = 1'b0;
    mptr      = 0;
    hs_count  = 0;
    check("rst_rsp_valid", longint'(rsp_valid), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_arr_row", longint'(arr_row), 0);
    check("rst_arr_col", longint'(arr_col), 0);
    check("rst_rsp_id", longint'(rsp_id), 0);
    check("rst_rsp_data", longint'(rsp_data), 0);
    check("rst_req_ready", longint'(req_ready), 0);
`ifdef SYSTOLIC_SCHED_CNT_EN
    check("rst_op_count", longint'(op_count), 0);
`endif
    rst_n = 1'b1;
  endtask

  task automatic drain(string name);
    int n = 0;
    gen_mode = 0;
    rdy_mode = 1;
    while ((exp_q.size() > 0 || in_flight || any_pend()) && n < 200) begin
      tick();
      n++;
    end
    if (exp_q.size() > 0 || in_flight || any_pend()) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=%0d pending responses required=0", name, exp_q.size());
    end
  endtask

  // Monitor: compares every response handshake against the scoreboard and
  // checks latency and stability under backpressure.
  initial begin
    bit             pv = 1'b0;
    bit             phs = 1'b0;
    logic [IDW-1:0] pid = '0;
    logic           pdata = 1'b0;
    exp_t           e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        pv  = 1'b0;
        phs = 1'b0;
      end else begin
        if (rsp_valid && !pv && exp_q.size() > 0)
          check("rsp_latency", cyc - exp_q[0].acc_cyc, SETTLE + 1);
        if (pv && !phs) begin
          check("hold_valid", longint'(rsp_valid), 1);
          check("hold_id", longint'(rsp_id), longint'(pid));
          check("hold_data", longint'(rsp_data), longint'(pdata));
        end
        if (rsp_valid && rsp_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rsp_unexpected actual=id %0d required=no response", rsp_id);
          end else begin
            e = exp_q.pop_front();
            check("rsp_id", longint'(rsp_id), e.id);
            check("rsp_data", longint'(rsp_data), longint'(e.data));
          end
          in_flight = 1'b0;
          hs_count++;
        end
        pv    = rsp_valid;
        phs   = rsp_valid && rsp_ready;
        pid   = rsp_id;
        pdata = rsp_data;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int gs;
    int n;
    int target;
    for (int k = 0; k < NREQ; k++) begin
      pend[k] = 1'b0;
      prow[k] = '0;
      pcol[k] = '0;
    end
    @(posedge clk);
    #1;
    do_reset();

    // Single directed request from requester 2 with the array tied high.
    tie1     = 1'b1;
    pend[2]  = 1'b1;
    prow[2]  = 4'hF;
    pcol[2]  = 12'h000;
    rdy_mode = 1;
    drive();
    tick();
    check("single_arr_row", longint'(arr_row), 'hF);
    check("single_arr_col", longint'(arr_col), 0);
    drain("single");
    check("arr_row_kept", longint'(arr_row), 'hF);
    tie1 = 1'b0;

    // Reset while settling: request abandoned, next grant goes to requester 0.
    pend[1] = 1'b1;
    prow[1] = 4'h5;
    pcol[1] = 12'hA5A;
    drive();
    tick();
    tick();
    do_reset();

    // All requesters continuously valid: grants 0,1,2,3,0 every SETTLE+2 cycles.
    gen_mode = 2;
    rdy_mode = 1;
    for (int k = 0; k < NREQ; k++) begin
      pend[k] = 1'b1;
      prow[k] = ROW'($urandom);
      pcol[k] = COLUMN'($urandom);
    end
    drive();
    gs = grants.size();
    n  = 0;
    while (grants.size() < gs + 5 && n < 100) begin
      tick();
      n++;
    end
    if (grants.size() < gs + 5) begin
      checks++;
      failures++;
      $display("FAIL rr_order_timeout actual=%0d grants required=5", grants.size() - gs);
    end else begin
      for (int i = 0; i < 5; i++) begin
        check("rr_order", grants[gs+i], i % NREQ);
        if (i > 0) check("rr_period", grant_cyc[gs+i] - grant_cyc[gs+i-1], SETTLE + 2);
      end
    end
    drain("rr");

    // Backpressure: response held for 10 cycles with a competing request waiting.
    gen_mode = 0;
    rdy_mode = 0;
    rsp_ready = 1'b0;
    pend[3] = 1'b1;
    prow[3] = ROW'($urandom);
    pcol[3] = COLUMN'($urandom);
    pend[0] = 1'b1;
    prow[0] = ROW'($urandom);
    pcol[0] = COLUMN'($urandom);
    drive();
    for (int i = 0; i < SETTLE + 1 + 10; i++) tick();
    check("bp_rsp_valid", longint'(rsp_valid), 1);
    check("bp_busy", longint'(busy), 1);
    drain("backpressure");

    // Random operands and handshakes against the array model.
    gen_mode = 1;
    rdy_mode = 2;
    target   = accepts + 200;
    n        = 0;
    while (accepts < target && n < 20000) begin
      tick();
      n++;
    end
    if (accepts < target) begin
      checks++;
      failures++;
      $display("FAIL random_timeout actual=%0d accepts required=%0d", accepts, target);
    end
    drain("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
